// File: rtl/shift_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : shift_pkg
//  Description : Shared constants, op encodings and FSM state type for the
//                iterative shift/rotate engine.
//  Revision    : 1.0  initial release
// ============================================================================
package shift_pkg;

    // Datapath geometry; the engine supports a 16-bit datapath only.
    localparam int WIDTH   = 16;
    localparam int SHAMT_W = 4;

    // Op encodings. Any op with bit 2 set decodes as rotate-right.
    localparam logic [2:0] OP_ROL = 3'b000;
    localparam logic [2:0] OP_SLL = 3'b001;
    localparam logic [2:0] OP_SRA = 3'b010;
    localparam logic [2:0] OP_SRL = 3'b011;
    localparam logic [2:0] OP_ROR = 3'b100;

    // Width of the per-step shift count (holds 1, 2 or 4).
    localparam int STEP_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage : shift_pkg
`default_nettype wire

// File: rtl/shift_step_unit.sv
`default_nettype none
// ============================================================================
//  Module      : shift_step_unit
//  Description : Combinational single step of the shift engine: applies one
//                shift/rotate of k bits (k = 1, 2, or 4) to the accumulator.
//  Revision    : 1.0  initial release
// ============================================================================
module shift_step_unit
    import shift_pkg::*;
#(
    parameter int STEP_WIDTH = WIDTH
) (
    input  logic [2:0]            op,
    input  logic [STEP_W-1:0]     k,
    input  logic [STEP_WIDTH-1:0] acc,
    output logic [STEP_WIDTH-1:0] stepped
);

    // Shift counts widened so the complementary rotate amount fits.
    logic [SHAMT_W:0] w_k;
    logic [SHAMT_W:0] w_k_inv;

    assign w_k     = {{(SHAMT_W + 1 - STEP_W){1'b0}}, k};
    assign w_k_inv = (SHAMT_W + 1)'(STEP_WIDTH) - w_k;

    // Select the stepped value; op[2] forces rotate-right regardless of op[1:0].
    always_comb begin
        stepped = acc;
        if (op[2]) begin
            stepped = (acc >> w_k) | (acc << w_k_inv);
        end else begin
            case (op[1:0])
                OP_ROL[1:0]: stepped = (acc << w_k) | (acc >> w_k_inv);
                OP_SLL[1:0]: stepped = acc << w_k;
                OP_SRA[1:0]: stepped = $signed(acc) >>> w_k;
                OP_SRL[1:0]: stepped = acc >> w_k;
                default:     stepped = acc;
            endcase
        end
    end

endmodule : shift_step_unit
`default_nettype wire

// File: rtl/iter_shift_unit.sv
`default_nettype none
// ============================================================================
//  Module      : iter_shift_unit
//  Description : Multi-cycle 16-bit shift/rotate engine with valid/ready
//                handshakes on request and result sides. One 1- or 2-bit
//                step is applied per cycle until the shift amount is used.
//                Optional macro ITER_SHIFT_STEP4_EN enables 4-bit steps.
//  Revision    : 1.0  initial release
// ============================================================================
module iter_shift_unit
    import shift_pkg::*;
#(
    parameter int DATA_W  = WIDTH,
    parameter int AMT_W   = SHAMT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] data_in,
    input  logic [AMT_W-1:0]  shamt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] data_out,
    output logic              busy
);

    state_t              r_state;
    logic [DATA_W-1:0]   r_acc;
    logic [AMT_W-1:0]    r_rem;
    logic [2:0]          r_op_q;
    logic                r_out_valid;
    logic                r_busy;

    logic [STEP_W-1:0]   w_k;
    logic [AMT_W-1:0]    w_k_ext;
    logic [DATA_W-1:0]   w_stepped;
    logic                w_accept;

    // Accept only in IDLE and never while reset is asserted.
    assign in_ready = (r_state == IDLE) & ~rst;
    assign w_accept = in_valid & in_ready;

    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign data_out  = r_acc;

    // Pick the largest step that does not overshoot the remaining amount.
    always_comb begin
        w_k = STEP_W'(1);
`ifdef ITER_SHIFT_STEP4_EN
        if (r_rem >= AMT_W'(4)) begin
            w_k = STEP_W'(4);
        end else if (r_rem >= AMT_W'(2)) begin
            w_k = STEP_W'(2);
        end
`else
        if (r_rem >= AMT_W'(2)) begin
            w_k = STEP_W'(2);
        end
`endif
    end

    assign w_k_ext = {{(AMT_W - STEP_W){1'b0}}, w_k};

    shift_step_unit #(
        .STEP_WIDTH (DATA_W)
    ) u_step (
        .op      (r_op_q),
        .k       (w_k),
        .acc     (r_acc),
        .stepped (w_stepped)
    );

    // Control FSM with accumulator, remaining count and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_rem       <= '0;
            r_op_q      <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_acc  <= data_in;
                        r_rem  <= shamt;
                        r_op_q <= op;
                        r_busy <= 1'b1;
                        if (shamt == '0) begin
                            r_state     <= DONE;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    r_acc <= w_stepped;
                    r_rem <= r_rem - w_k_ext;
                    if (r_rem == w_k_ext) begin
                        r_state     <= DONE;
                        r_out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    // Result held until the consumer takes it; no bypass to a new request.
                    if (out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule : iter_shift_unit
`default_nettype wire
